// File: rtl/fsm_serial_pkg.sv
// Shared types and constants for the parametrised serial frame receiver.
package fsm_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } rx_state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

endpackage

// File: rtl/fsm_serial_rx_param.sv
// Serial frame receiver, one bit per clock: start, DATA_W data bits LSB-first,
// optional parity, STOP_BITS stop bits. Registered done / parity / framing pulses.
module fsm_serial_rx_param
    import fsm_serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int CNT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic PAR_INIT = (PARITY_ODD == PAR_ODD);
    localparam logic PAR_ON   = (PARITY_EN != 0);

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              par_q, par_d;
    logic              done_q, done_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic [DATA_W:0]   shift_in;
    logic              par_bad;

    // Widened by one bit so the shift also works for DATA_W = 1.
    assign shift_in = {in, shift_q};
    // par_q already holds the parity bit by the time the stop bits are sampled.
    assign par_bad  = PAR_ON & par_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            out_data_q   <= '0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            out_data_q   <= out_data_d;
            done_q       <= done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!in) state_d = ST_DATA;
            ST_DATA:   if (cnt_q == DATA_LAST) state_d = PAR_ON ? ST_PARITY : ST_STOP;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
                if (!in)                     state_d = ST_ERR;
                else if (cnt_q == STOP_LAST) state_d = ST_DONE;
            end
            ST_DONE:   state_d = in ? ST_IDLE : ST_DATA;
            ST_ERR:    if (in) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        out_data_d   = out_data_q;
        done_d       = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (!in) begin
                    cnt_d = '0;
                    par_d = PAR_INIT;
                end
            end
            ST_DATA: begin
                shift_d = shift_in[DATA_W:1];
                par_d   = par_q ^ in;
                cnt_d   = (cnt_q == DATA_LAST) ? '0 : cnt_q + 1'b1;
            end
            ST_PARITY: begin
                par_d = par_q ^ in;
                cnt_d = '0;
            end
            ST_STOP: begin
                if (!in) begin
                    frame_err_d = 1'b1;
                end else if (cnt_q == STOP_LAST) begin
                    out_data_d   = shift_q;
                    done_d       = ~par_bad;
                    parity_err_d = par_bad;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign out_data   = out_data_q;
    assign done       = done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fsm_serial_rx_param.sv
// Directed bench for fsm_serial_rx_param: 8N1, even parity and two-stop-bit instances.
module tb_fsm_serial_rx_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_a = 1'b1, in_p = 1'b1, in_s = 1'b1;
    logic [7:0] out_a, out_p, out_s;
    logic       done_a, done_p, done_s;
    logic       pe_a, pe_p, pe_s;
    logic       fe_a, fe_p, fe_s;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t0 = 0;

    always #5 clk = ~clk;

    fsm_serial_rx_param #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .in(in_a), .out_data(out_a),
        .done(done_a), .parity_err(pe_a), .frame_err(fe_a));

    fsm_serial_rx_param #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
        .clk(clk), .reset(reset), .in(in_p), .out_data(out_p),
        .done(done_p), .parity_err(pe_p), .frame_err(fe_p));

    fsm_serial_rx_param #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_s (
        .clk(clk), .reset(reset), .in(in_s), .out_data(out_s),
        .done(done_s), .parity_err(pe_s), .frame_err(fe_s));

    // which: 0 = 8N1, 1 = even parity, 2 = two stop bits; the other lines idle high.
    task automatic step(input int which, input logic b);
        in_a = (which == 0) ? b : 1'b1;
        in_p = (which == 1) ? b : 1'b1;
        in_s = (which == 2) ? b : 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) step(which, bits[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(0, 1'b1);
        step(0, 1'b1);
        checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL rst_out_a got %h want 00", out_a); end
        checks++; if (out_p !== 8'h00) begin errors++; $display("FAIL rst_out_p got %h want 00", out_p); end
        checks++; if (out_s !== 8'h00) begin errors++; $display("FAIL rst_out_s got %h want 00", out_s); end
        checks++; if ({done_a, pe_a, fe_a, done_p, pe_p, fe_p, done_s, pe_s, fe_s} !== 9'b0) begin
            errors++; $display("FAIL rst_pulses got %b want 000000000",
                               {done_a, pe_a, fe_a, done_p, pe_p, fe_p, done_s, pe_s, fe_s});
        end
        reset = 1'b0;
        step(0, 1'b1);
    endtask

    task automatic test_8n1();
        step(0, 1'b1);
        send(0, {7'h0, 8'hA5, 1'b0}, 9);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL 8n1_early got %b want 0", done_a); end
        step(0, 1'b1);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL 8n1_done got %b want 1", done_a); end
        checks++; if (out_a !== 8'hA5) begin errors++; $display("FAIL 8n1_data got %h want a5", out_a); end
        checks++; if ({pe_a, fe_a} !== 2'b00) begin errors++; $display("FAIL 8n1_errs got %b want 00", {pe_a, fe_a}); end
        step(0, 1'b1);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL 8n1_pulse_len got %b want 0", done_a); end
    endtask

    task automatic test_parity();
        send(1, {7'h0, 8'h03, 1'b0}, 9);
        step(1, 1'b0);
        checks++; if (done_p !== 1'b0) begin errors++; $display("FAIL par_early got %b want 0", done_p); end
        step(1, 1'b1);
        checks++; if ({done_p, pe_p, fe_p} !== 3'b100) begin errors++; $display("FAIL par_good got %b want 100", {done_p, pe_p, fe_p}); end
        checks++; if (out_p !== 8'h03) begin errors++; $display("FAIL par_good_data got %h want 03", out_p); end
        step(1, 1'b1);
        send(1, {7'h0, 8'h03, 1'b0}, 9);
        step(1, 1'b1);
        step(1, 1'b1);
        checks++; if ({done_p, pe_p, fe_p} !== 3'b010) begin errors++; $display("FAIL par_bad got %b want 010", {done_p, pe_p, fe_p}); end
        checks++; if (out_p !== 8'h03) begin errors++; $display("FAIL par_bad_data got %h want 03", out_p); end
        step(1, 1'b1);
        checks++; if (pe_p !== 1'b0) begin errors++; $display("FAIL par_pulse_len got %b want 0", pe_p); end
        // Three ones with parity bit 0 is odd overall: bad, yet the word still loads.
        send(1, {7'h0, 8'h07, 1'b0}, 9);
        step(1, 1'b0);
        step(1, 1'b1);
        checks++; if ({done_p, pe_p} !== 2'b01) begin errors++; $display("FAIL par_bad2 got %b want 01", {done_p, pe_p}); end
        checks++; if (out_p !== 8'h07) begin errors++; $display("FAIL par_bad2_data got %h want 07", out_p); end
        step(1, 1'b1);
    endtask

    task automatic test_frame_err();
        send(0, {7'h0, 8'h5A, 1'b0}, 9);
        step(0, 1'b0);
        checks++; if ({done_a, pe_a, fe_a} !== 3'b001) begin errors++; $display("FAIL ferr_pulse got %b want 001", {done_a, pe_a, fe_a}); end
        checks++; if (out_a !== 8'hA5) begin errors++; $display("FAIL ferr_hold got %h want a5", out_a); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1'b0);
            checks++; if ({done_a, fe_a} !== 2'b00) begin errors++; $display("FAIL ferr_stay%0d got %b want 00", i, {done_a, fe_a}); end
        end
        step(0, 1'b1);
        send(0, {7'h0, 8'h11, 1'b0}, 9);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL ferr_recover_early got %b want 0", done_a); end
        step(0, 1'b1);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL ferr_recover_done got %b want 1", done_a); end
        checks++; if (out_a !== 8'h11) begin errors++; $display("FAIL ferr_recover_data got %h want 11", out_a); end
        step(0, 1'b1);
    endtask

    task automatic test_stop2();
        send(2, {7'h0, 8'hFF, 1'b0}, 9);
        step(2, 1'b1);
        checks++; if ({done_s, fe_s} !== 2'b00) begin errors++; $display("FAIL s2_first_stop got %b want 00", {done_s, fe_s}); end
        step(2, 1'b0);
        checks++; if ({done_s, pe_s, fe_s} !== 3'b001) begin errors++; $display("FAIL s2_ferr got %b want 001", {done_s, pe_s, fe_s}); end
        checks++; if (out_s !== 8'h00) begin errors++; $display("FAIL s2_ferr_hold got %h want 00", out_s); end
        step(2, 1'b1);
        send(2, {7'h0, 8'hFF, 1'b0}, 9);
        step(2, 1'b1);
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL s2_early got %b want 0", done_s); end
        step(2, 1'b1);
        checks++; if (done_s !== 1'b1) begin errors++; $display("FAIL s2_done got %b want 1", done_s); end
        checks++; if (out_s !== 8'hFF) begin errors++; $display("FAIL s2_data got %h want ff", out_s); end
        step(2, 1'b1);
    endtask

    task automatic test_back_to_back();
        send(0, {7'h0, 8'h01, 1'b0}, 9);
        step(0, 1'b1);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", done_a); end
        checks++; if (out_a !== 8'h01) begin errors++; $display("FAIL b2b_data1 got %h want 01", out_a); end
        t0 = cyc;
        step(0, 1'b0);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL b2b_pulse_len got %b want 0", done_a); end
        send(0, {8'h0, 8'h80}, 8);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL b2b_early got %b want 0", done_a); end
        step(0, 1'b1);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", done_a); end
        checks++; if (out_a !== 8'h80) begin errors++; $display("FAIL b2b_data2 got %h want 80", out_a); end
        checks++; if (cyc - t0 !== 10) begin errors++; $display("FAIL b2b_spacing got %0d want 10", cyc - t0); end
        step(0, 1'b1);
    endtask

    task automatic test_reset_mid();
        send(0, {7'h0, 8'hC3, 1'b0}, 5);
        reset = 1'b1;
        in_a  = 1'b1;
        #1;
        checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL rmid_out got %h want 00", out_a); end
        checks++; if ({done_a, pe_a, fe_a} !== 3'b000) begin errors++; $display("FAIL rmid_pulses got %b want 000", {done_a, pe_a, fe_a}); end
        #10;
        reset = 1'b0;
        send(0, {7'h0, 8'hC3, 1'b0}, 9);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rmid_early got %b want 0", done_a); end
        step(0, 1'b1);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL rmid_done got %b want 1", done_a); end
        checks++; if (out_a !== 8'hC3) begin errors++; $display("FAIL rmid_data got %h want c3", out_a); end
        step(0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_stop2();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_serial_rx_param.md
Name: fsm_serial_rx_param

Overview:
- Parametrised serial frame receiver and successor to the fixed 8N1 serial-frame FSM.
- Samples one bit per clock: start bit (0), DATA_W data bits LSB-first, optional parity bit, STOP_BITS stop bits (1).
- Outputs the assembled word with a one-cycle done pulse, plus distinct parity-error and framing-error pulses.
- Sits directly behind an already-synchronised serial input; one bit period equals one clk cycle, with no oversampling.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of required stop bits (1 or 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  reset is asynchronous and active-high.
- in  input  1  serial line; idle level 1.
- out_data  output  DATA_W  last received word, LSB = first data bit received.
- done  output  1  one-cycle pulse: frame received with valid stops and valid parity.
- parity_err  output  1  one-cycle pulse: frame had valid stops but bad parity.
- frame_err  output  1  one-cycle pulse: a stop bit was sampled as 0.

Behaviour:
- States: IDLE, DATA, PARITY, STOP, DONE, ERR.
- Internal registers: bit counter cnt (clog2 of max(DATA_W, STOP_BITS) bits), shift register, running parity par_q.
- Reset, asynchronous: state=IDLE, cnt=0, shift=0, par_q=0, out_data=0, done=0, parity_err=0, frame_err=0.
- IDLE: in=0 is the start bit; go to DATA with cnt=0 and par_q=PARITY_ODD. in=1 stays in IDLE.
- DATA:
  - Each cycle, shift in into the shift register (LSB-first fill) and update par_q ^= in.
  - After DATA_W samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: one cycle; par_q ^= in; go to STOP with cnt=0.
- STOP:
  - Each cycle samples in. in=0 goes to ERR immediately; remaining stop bits are not sampled.
  - After STOP_BITS samples of 1, go to DONE.
- DONE, one cycle:
  - out_data is loaded from the shift register on entry to DONE, regardless of parity result.
  - done = ~par_bad and parity_err = par_bad, where par_bad = PARITY_EN & par_q.
  - Transition: in=0 is a back-to-back start bit, go to DATA (initialise as in IDLE); in=1 goes to IDLE.
- ERR:
  - frame_err is high for exactly the first cycle in ERR.
  - Stay in ERR while in=0; in=1 goes to IDLE. A start bit is not accepted directly from ERR.
- Output timing:
  - done, parity_err and frame_err are registered and never more than one is high in a cycle.
  - Latency, start-bit sample cycle to done cycle: 1 + DATA_W + PARITY_EN + STOP_BITS cycles.
- out_data holds its value until the next DONE entry; it is unaffected by ERR.
- Reset asserted mid-frame aborts the frame: state IDLE, out_data=0, no pulse emitted. The first sample after release is treated as in IDLE.

Decomposition:
- Package fsm_serial_pkg: state enum typedef (rx_state_t, 3 bits), parity mode constants PAR_EVEN=0 and PAR_ODD=1.
- No sub-module: counter, shift register and parity are small enough to stay inline in one sequential and one combinational process.

Test Plan:
- Frame 8N1 (defaults), in = 1, 0, 1,0,1,0,0,1,0,1, 1 -> done=1 for one cycle, 10 cycles after the start-bit sample; out_data=8'hA5; no error pulses.
- PARITY_EN=1, PARITY_ODD=0, byte 8'h03, parity bit 0, stop 1 -> done=1, out_data=8'h03. Same frame with parity bit 1 -> parity_err=1, done=0, out_data=8'h03.
- 8N1 byte 8'h5A with stop bit 0 -> frame_err=1 for one cycle, done=0, out_data keeps previous value. Then in=0 for 3 cycles -> stays in ERR. Then in=1 -> IDLE, and a following valid 8'h11 frame gives done with out_data=8'h11.
- STOP_BITS=2, frame 8'hFF with stops 1,0 -> frame_err. Stops 1,1 -> done, 11 cycles after the start-bit sample.
- Back-to-back 8N1 frames 8'h01 then 8'h80, with in=0 sampled in the DONE cycle -> two done pulses exactly 10 cycles apart, out_data=8'h01 then 8'h80.
- reset pulsed mid-data (after 4 data bits) -> immediate state IDLE and out_data=0. A subsequent full frame 8'hC3 -> done with out_data=8'hC3.
